// File: rtl/rgb_pwm_fader.sv
// RGB LED driver: synchronises a 3-bit colour, fades the new colour in over PWM periods, then holds at duty.
// Optional blinking is compiled in with `define RGB_BLINK_EN.
module rgb_pwm_fader #(
   parameter int CLK_DIV       = 1000,
   parameter int BLINK_PERIODS = 32
) (
   input  logic       clk,
   input  logic       rst,
   input  logic       r_in,
   input  logic       g_in,
   input  logic       b_in,
   input  logic [3:0] duty,
   input  logic       blink_en,
   output logic       rgb_led_r,
   output logic       rgb_led_g,
   output logic       rgb_led_b,
   output logic       period_end
);

   localparam logic [15:0] DIV_LAST = 16'(CLK_DIV - 1);

   typedef enum logic {HOLD, RAMP} state_t;

   // Colour code is {r, g, b}, so bit 2 drives red.
   logic [2:0]  code_p0;
   logic [2:0]  code_s;
   logic [2:0]  code_l;
   logic [3:0]  level;
   state_t      state;
   logic [15:0] presc;
   logic [15:0] presc_nxt;
   logic [3:0]  pwm_cnt;
   logic [3:0]  pwm_nxt;
   logic        tick;
   logic        blink_gate;

   function automatic logic [3:0] ramp_step(input logic [3:0] lvl, input logic [3:0] tgt);
      return (lvl < tgt) ? lvl + 4'd1 : tgt;
   endfunction

   // Stage p0/s: two-flop synchroniser for the asynchronous colour inputs
   always_ff @(posedge clk) begin
      if (rst) begin
         code_p0 <= '0;
         code_s  <= '0;
      end else begin
         code_p0 <= {r_in, g_in, b_in};
         code_s  <= code_p0;
      end
   end

   always_comb begin
      tick      = (presc == DIV_LAST);
      presc_nxt = tick ? 16'd0 : presc + 16'd1;
      pwm_nxt   = tick ? pwm_cnt + 4'd1 : pwm_cnt;
   end

   // period_end is registered from the next-state values so it is high while the last step is in progress
   always_ff @(posedge clk) begin
      if (rst) begin
         presc      <= '0;
         pwm_cnt    <= '0;
         period_end <= 1'b0;
      end else begin
         presc      <= presc_nxt;
         pwm_cnt    <= pwm_nxt;
         period_end <= (presc_nxt == DIV_LAST) && (pwm_nxt == 4'hF);
      end
   end

   // Fade controller: a colour change always wins and restarts the ramp from dark
   always_ff @(posedge clk) begin
      if (rst) begin
         state  <= HOLD;
         code_l <= '0;
         level  <= '0;
      end else if (code_s != code_l) begin
         code_l <= code_s;
         level  <= '0;
         state  <= RAMP;
      end else if (period_end) begin
         case (state)
            RAMP: begin
               level <= ramp_step(level, duty);
               if (level >= duty) state <= HOLD;
            end
            default: level <= duty;
         endcase
      end
   end

`ifdef RGB_BLINK_EN
   localparam logic [7:0] BLINK_LAST = 8'(BLINK_PERIODS - 1);

   logic [7:0] blink_cnt;
   logic       blink_phase;

   always_ff @(posedge clk) begin
      if (rst || !blink_en) begin
         blink_cnt   <= '0;
         blink_phase <= 1'b0;
      end else if (period_end) begin
         if (blink_cnt == BLINK_LAST) begin
            blink_cnt   <= '0;
            blink_phase <= ~blink_phase;
         end else begin
            blink_cnt <= blink_cnt + 8'd1;
         end
      end
   end

   assign blink_gate = ~blink_en | blink_phase;
`else
   logic unused_blink;

   assign blink_gate   = 1'b1;
   assign unused_blink = blink_en ^ (BLINK_PERIODS > 0);
`endif

   // Output stage: registered PWM compare; level only moves on period_end so periods never glitch
   always_ff @(posedge clk) begin
      if (rst) begin
         rgb_led_r <= 1'b0;
         rgb_led_g <= 1'b0;
         rgb_led_b <= 1'b0;
      end else begin
         rgb_led_r <= code_l[2] & (pwm_cnt < level) & blink_gate;
         rgb_led_g <= code_l[1] & (pwm_cnt < level) & blink_gate;
         rgb_led_b <= code_l[0] & (pwm_cnt < level) & blink_gate;
      end
   end

endmodule

// File: tb/tb_rgb_pwm_fader.sv
// Directed bench for rgb_pwm_fader at CLK_DIV=2 (32 clk per PWM period, 2 clk high per level step).
module tb_rgb_pwm_fader;

   logic       clk = 1'b0;
   logic       rst;
   logic       r_in, g_in, b_in;
   logic [3:0] duty;
   logic       blink_en;
   logic       rgb_led_r, rgb_led_g, rgb_led_b;
   logic       period_end;

   int checks = 0;
   int errors = 0;

   rgb_pwm_fader #(.CLK_DIV(2), .BLINK_PERIODS(2)) dut (
      .clk(clk), .rst(rst), .r_in(r_in), .g_in(g_in), .b_in(b_in),
      .duty(duty), .blink_en(blink_en),
      .rgb_led_r(rgb_led_r), .rgb_led_g(rgb_led_g), .rgb_led_b(rgb_led_b),
      .period_end(period_end)
   );

   always #5 clk = ~clk;

   typedef struct {
      logic [2:0] code;
      logic [3:0] duty;
      int         er;
      int         eg;
      int         eb;
   } vec_t;

   vec_t vecs[6];

   task automatic check(input string name, input int act, input int exp);
      checks++;
      if (act != exp) begin
         errors++;
         $display("FAIL %s: got %0d, expected %0d", name, act, exp);
      end
   endtask

   task automatic set_code(input logic [2:0] c);
      {r_in, g_in, b_in} = c;
   endtask

   // Advance to the next negedge where period_end is high, bounded.
   task automatic wait_pe();
      int n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (!period_end && n < 40);
      check("period_end_found", int'(period_end), 1);
   endtask

   // Starting at a period_end negedge, count high samples over the next 32 negedges.
   task automatic measure(output int cr, output int cg, output int cb,
                          input int chg_at, input logic [3:0] nd);
      int pe_cnt = 0;
      cr = 0; cg = 0; cb = 0;
      for (int i = 1; i <= 32; i++) begin
         @(negedge clk);
         cr += int'(rgb_led_r);
         cg += int'(rgb_led_g);
         cb += int'(rgb_led_b);
         pe_cnt += int'(period_end);
         if (i == chg_at) duty = nd;
      end
      check("period_end_window", int'(pe_cnt == 1 && period_end), 1);
   endtask

   task automatic skip(input int n);
      int a, b, c;
      repeat (n) measure(a, b, c, -1, 4'd0);
   endtask

   task automatic window_chk(input string tag, input int er, input int eg, input int eb,
                             input int chg_at, input logic [3:0] nd);
      int cr, cg, cb;
      measure(cr, cg, cb, chg_at, nd);
      check({tag, "_r"}, cr, er);
      check({tag, "_g"}, cg, eg);
      check({tag, "_b"}, cb, eb);
   endtask

   initial begin
      #2_000_000;
      $display("FAIL watchdog: got timeout, expected completion");
      $fatal(1, "watchdog");
   end

   initial begin
      int cnt;
      int n;
      vecs[0] = '{3'b101, 4'd7,  14, 0,  14};
      vecs[1] = '{3'b010, 4'd15, 0,  30, 0};
      vecs[2] = '{3'b111, 4'd1,  2,  2,  2};
      vecs[3] = '{3'b111, 4'd9,  18, 18, 18};
      vecs[4] = '{3'b000, 4'd9,  0,  0,  0};
      vecs[5] = '{3'b110, 4'd0,  0,  0,  0};

      rst = 1'b1; set_code(3'b000); duty = 4'd0; blink_en = 1'b0;
      repeat (3) @(negedge clk);
      check("reset_r", int'(rgb_led_r), 0);
      check("reset_g", int'(rgb_led_g), 0);
      check("reset_b", int'(rgb_led_b), 0);
      check("reset_pe", int'(period_end), 0);

      // Full ramp of red to 15 after reset
      rst = 1'b0; set_code(3'b100); duty = 4'd15;
      wait_pe();
      for (int k = 1; k <= 16; k++)
         window_chk($sformatf("ramp15_%0d", k), 2 * ((k > 15) ? 15 : k), 0, 0, -1, 4'd0);

      // duty 0: HOLD on first period_end, then duty tracks directly
      set_code(3'b011); duty = 4'd0;
      skip(1);
      window_chk("duty0", 0, 0, 0, -1, 4'd0);
      duty = 4'd6;
      window_chk("duty0_hold_track", 0, 12, 12, -1, 4'd0);

      // Ramp to 3 reaches HOLD on the 4th period_end
      set_code(3'b110); duty = 4'd3;
      skip(1);
      for (int k = 1; k <= 4; k++)
         window_chk($sformatf("ramp3_%0d", k), 2 * ((k > 3) ? 3 : k), 2 * ((k > 3) ? 3 : k), 0, -1, 4'd0);
      duty = 4'd10;
      window_chk("ramp3_hold_jump", 20, 20, 0, -1, 4'd0);

      // Switch colour mid-ramp at level 5
      set_code(3'b010); duty = 4'd15;
      skip(1);
      for (int k = 1; k <= 4; k++)
         window_chk($sformatf("ramp_g_%0d", k), 0, 2 * k, 0, -1, 4'd0);
      repeat (2) @(negedge clk);
      check("switch_g_before", int'(rgb_led_g), 1);
      set_code(3'b001);
      repeat (3) @(negedge clk);
      check("switch_g_3clk", int'(rgb_led_g), 1);
      @(negedge clk);
      check("switch_g_4clk", int'(rgb_led_g), 0);
      check("switch_b_4clk", int'(rgb_led_b), 0);
      wait_pe();
      window_chk("switch_b_1", 0, 0, 2, -1, 4'd0);
      window_chk("switch_b_2", 0, 0, 4, -1, 4'd0);

      // Reset pulse mid-ramp
      set_code(3'b100); duty = 4'd15;
      skip(1);
      for (int k = 1; k <= 3; k++)
         window_chk($sformatf("pre_rst_%0d", k), 2 * k, 0, 0, -1, 4'd0);
      repeat (4) @(negedge clk);
      check("pre_rst_r_high", int'(rgb_led_r), 1);
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("rst_pulse_r", int'(rgb_led_r), 0);
      check("rst_pulse_g", int'(rgb_led_g), 0);
      check("rst_pulse_b", int'(rgb_led_b), 0);
      check("rst_pulse_pe", int'(period_end), 0);
      cnt = 0; n = 0;
      do begin
         @(negedge clk);
         cnt += int'(rgb_led_r);
         n++;
      end while (!period_end && n < 40);
      check("post_rst_found_pe", int'(period_end), 1);
      check("post_rst_dark", cnt, 0);
      window_chk("post_rst_1", 2, 0, 0, -1, 4'd0);
      window_chk("post_rst_2", 4, 0, 0, -1, 4'd0);

      // HOLD at 12, duty drops to 4 mid-period: takes effect only at the boundary
      duty = 4'd12;
      skip(12);
      window_chk("duty_drop_cur", 24, 0, 0, 10, 4'd4);
      window_chk("duty_drop_next", 8, 0, 0, -1, 4'd0);

      for (int i = 0; i < 6; i++) begin
         set_code(vecs[i].code); duty = vecs[i].duty;
         skip(17);
         window_chk($sformatf("vec%0d", i), vecs[i].er, vecs[i].eg, vecs[i].eb, -1, 4'd0);
      end

`ifdef RGB_BLINK_EN
      set_code(3'b100); duty = 4'd8;
      skip(10);
      window_chk("blink_pre", 16, 0, 0, -1, 4'd0);
      blink_en = 1'b1;
      window_chk("blink_0", 0,  0, 0, -1, 4'd0);
      window_chk("blink_1", 16, 0, 0, -1, 4'd0);
      window_chk("blink_2", 16, 0, 0, -1, 4'd0);
      window_chk("blink_3", 0,  0, 0, -1, 4'd0);
      window_chk("blink_4", 0,  0, 0, -1, 4'd0);
      window_chk("blink_5", 16, 0, 0, -1, 4'd0);
      blink_en = 1'b0;
      window_chk("blink_off", 16, 0, 0, -1, 4'd0);
`endif

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

endmodule

// File: doc/rgb_pwm_fader.md
RGB_PWM_FADER -- requirements
Module: rgb_pwm_fader

Interface
REQ-001 Parameter: CLK_DIV, default 1000, clk cycles per PWM step (legal range 2..65535).
REQ-002 Parameter: BLINK_PERIODS, default 32, PWM periods per blink half-phase (legal range 1..255; used only with RGB_BLINK_EN).
REQ-003 Port: clk  input  1  single system clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  reset; synchronous, active-high.
REQ-005 Port: r_in / g_in / b_in  input  1 each  colour levels from the upstream comparator stage; asynchronous to clk, quasi-static.
REQ-006 Port: duty  input  4  target brightness, 0 = off, 15 = 15/16 on; quasi-static.
REQ-007 Port: blink_en  input  1  requests blinking; ignored without RGB_BLINK_EN.
REQ-008 Port: rgb_led_r / rgb_led_g / rgb_led_b  output  1 each  registered PWM drive to the board LED.
REQ-009 Port: period_end  output  1  registered one-cycle pulse on the last clk of each PWM period.

Function
REQ-010 Inputs r_in, g_in and b_in SHALL pass through a 2-flop synchroniser; the synchronised triple is code_s[2:0].
REQ-011 Prescaler SHALL count 0..CLK_DIV-1 and wrap; tick is asserted when the prescaler equals CLK_DIV-1.
REQ-012 4-bit pwm_cnt SHALL increment on tick and wrap 15->0; period_end SHALL be asserted on the clk where the prescaler equals CLK_DIV-1 and pwm_cnt equals 15.
REQ-013 The block SHALL hold a latched colour code_l[2:0] and a 4-bit level; the FSM states SHALL be HOLD and RAMP.
REQ-014 Change: in any state, when code_s != code_l, the block SHALL load code_l <= code_s and level <= 0 and enter RAMP on the next clk; a change SHALL take priority over all other updates that cycle.
REQ-015 In RAMP, on period_end with level < duty, level SHALL be incremented by 1; with level >= duty, level SHALL be set to duty and the FSM SHALL enter HOLD.
REQ-016 In HOLD, on period_end, level SHALL be set to duty so that duty changes track once per period; level SHALL never change except on period_end or a change event.
REQ-017 The next-cycle output SHALL be rgb_led_x <= code_l[x] & (pwm_cnt < level) & blink_gate; level 0 SHALL give a constant 0 output, and level 15 SHALL give 15 of 16 steps high.
REQ-018 A full ramp from 0 to duty D SHALL take D+1 period_end events to reach HOLD, counted from the change event.
REQ-019 Latency from an input edge to the code_l update SHALL be 3 clk: 2 clk of synchroniser and 1 clk of latch.
REQ-020 If code_s toggles during RAMP, the ramp SHALL restart from 0 with the new code; no partial level SHALL be retained.

Reset
REQ-021 While rst is high on a clk edge, the following SHALL all be cleared to 0: the synchroniser, code_l, level, the prescaler, pwm_cnt, the blink state and every output; the FSM SHALL enter HOLD.
REQ-022 If a nonzero code is present after reset, it SHALL be detected as a change and SHALL start a RAMP.
REQ-023 rst asserted mid-RAMP SHALL abort the ramp; no state SHALL survive the reset.

Configuration
REQ-024 Macro RGB_BLINK_EN defined: a period counter SHALL count period_end pulses and toggle blink_phase every BLINK_PERIODS periods, and blink_gate SHALL equal ~blink_en | blink_phase.
REQ-025 While blink_en is low, the blink counter and blink_phase SHALL be held at 0.
REQ-026 Macro RGB_BLINK_EN undefined: blink_gate SHALL be constantly 1, blink_en SHALL be unused, and no blink logic SHALL be synthesised.

Verification
REQ-027 Scenario: CLK_DIV=2, duty=15, apply rgb=100 after reset -> rgb_led_r ramps 1/16..15/16 over 16 periods; g and b stay 0; FSM reaches HOLD after 16 period_end events.
REQ-028 Scenario: duty=0, apply rgb=011 -> all outputs stay 0; FSM enters HOLD on the first period_end.
REQ-029 Scenario: mid-RAMP at level 5, switch rgb from 010 to 001 -> level is 0 on the next clk; b ramps from 0; g is 0 from 4 clk after the input edge.
REQ-030 Scenario: in HOLD with duty 12, change duty to 4 -> the output changes from 12/16 to 4/16 exactly at the next period boundary, with no mid-period glitch.
REQ-031 Scenario: rst pulsed for 1 clk mid-RAMP -> every output is 0 on the next clk, level is 0, and with the input held a fresh ramp starts from 0.
REQ-032 Scenario (RGB_BLINK_EN, BLINK_PERIODS=2, blink_en=1, HOLD at duty 8) -> outputs alternate 2 periods dark and 2 periods at 8/16; blink_en=0 restores continuous output.
